// File: rtl/pipe_reg_chain.sv
// Parametrised decode/result pipeline register chain with stall, flush, late result capture
// and combinational operand forwarding. Optional counters are enabled by PIPE_REG_CHAIN_PERF_EN.
module pipe_reg_chain #(
    parameter int NUM_STAGES = 3,
    parameter int PAYLOAD_W  = 64,
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 3,
    parameter int NUM_SRC    = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [PAYLOAD_W-1:0]          in_payload,
    input  logic [IDX_W-1:0]              in_dst,
    input  logic                          in_wr,
    output logic                          in_ready,
    input  logic [NUM_STAGES-1:0]         stall,
    input  logic [NUM_STAGES-1:0]         flush,
    input  logic [NUM_STAGES-1:0]         res_we,
    input  logic [NUM_STAGES*DATA_W-1:0]  res_data,
    input  logic [NUM_SRC*IDX_W-1:0]      q_idx,
    output logic [NUM_SRC-1:0]            q_hit,
    output logic [NUM_SRC-1:0]            q_pend,
    output logic [NUM_SRC*DATA_W-1:0]     q_data,
    output logic [NUM_STAGES-1:0]         stg_valid,
    output logic [NUM_STAGES*PAYLOAD_W-1:0] stg_payload,
    output logic                          out_valid,
    output logic                          out_wr,
    output logic [IDX_W-1:0]              out_dst,
    output logic [DATA_W-1:0]             out_res
`ifdef PIPE_REG_CHAIN_PERF_EN
    ,
    output logic [31:0]                   perf_retired,
    output logic [31:0]                   perf_bubbles,
    output logic [31:0]                   perf_flushed
`endif
);

    localparam int unsigned LAST = NUM_STAGES - 1;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [IDX_W-1:0]     dst;
        logic                 res_ok;
        logic [DATA_W-1:0]    res;
        logic [PAYLOAD_W-1:0] payload;
    } stage_t;

    stage_t                stg_q [NUM_STAGES];
    stage_t                stg_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] hold;

    // A stall freezes its own stage and every younger one.
    always_comb begin
        hold = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            for (int i = k; i < NUM_STAGES; i++) begin
                hold[k] = hold[k] | stall[i];
            end
        end
    end

    assign in_ready = !hold[0];

    // Per-stage next state: flush, then hold, then load/bubble/shift.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            stg_d[k] = stg_q[k];
        end

        if (flush[0]) begin
            stg_d[0].valid = 1'b0;
        end else if (!hold[0]) begin
            stg_d[0].valid   = in_valid;
            stg_d[0].wr      = in_wr;
            stg_d[0].dst     = in_dst;
            stg_d[0].payload = in_payload;
            stg_d[0].res_ok  = 1'b0;
            stg_d[0].res     = '0;
            if (res_we[0]) begin
                stg_d[0].res_ok = 1'b1;
                stg_d[0].res    = res_data[DATA_W-1:0];
            end
        end

        for (int k = 1; k < NUM_STAGES; k++) begin
            if (flush[k]) begin
                stg_d[k].valid = 1'b0;
            end else if (!hold[k]) begin
                if (hold[k-1]) begin
                    stg_d[k].valid = 1'b0;
                end else begin
                    stg_d[k] = stg_q[k-1];
                    if (res_we[k]) begin
                        stg_d[k].res_ok = 1'b1;
                        stg_d[k].res    = res_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    // Forwarding: scan oldest to youngest so the youngest writer overrides.
    always_comb begin
        q_hit  = '0;
        q_pend = '0;
        q_data = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (stg_q[k].valid && stg_q[k].wr &&
                    (stg_q[k].dst == q_idx[j*IDX_W +: IDX_W])) begin
                    q_hit[j]                    = stg_q[k].res_ok;
                    q_pend[j]                   = !stg_q[k].res_ok;
                    q_data[j*DATA_W +: DATA_W]  = stg_q[k].res_ok ? stg_q[k].res : '0;
                end
            end
        end
    end

    always_comb begin
        stg_valid   = '0;
        stg_payload = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stg_valid[k]                          = stg_q[k].valid;
            stg_payload[k*PAYLOAD_W +: PAYLOAD_W] = stg_q[k].payload;
        end
    end

    assign out_valid = stg_q[LAST].valid;
    assign out_wr    = stg_q[LAST].wr;
    assign out_dst   = stg_q[LAST].dst;
    assign out_res   = stg_q[LAST].res;

`ifdef PIPE_REG_CHAIN_PERF_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] perf_retired_q, perf_retired_d;
    logic [CNT_W-1:0] perf_bubbles_q, perf_bubbles_d;
    logic [CNT_W-1:0] perf_flushed_q, perf_flushed_d;
    logic             retire_ev;
    logic             bubble_ev;
    logic             flush_ev;

    // Saturating event counters.
    always_comb begin
        retire_ev = stg_q[LAST].valid && !hold[LAST];
        flush_ev  = |(flush & stg_valid);
        bubble_ev = 1'b0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (!flush[k] && !hold[k] && hold[k-1]) begin
                bubble_ev = 1'b1;
            end
        end
        perf_retired_d = perf_retired_q;
        perf_bubbles_d = perf_bubbles_q;
        perf_flushed_d = perf_flushed_q;
        if (retire_ev && (perf_retired_q != '1)) perf_retired_d = perf_retired_q + CNT_W'(1);
        if (bubble_ev && (perf_bubbles_q != '1)) perf_bubbles_d = perf_bubbles_q + CNT_W'(1);
        if (flush_ev  && (perf_flushed_q != '1)) perf_flushed_d = perf_flushed_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_retired_q <= '0;
            perf_bubbles_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_bubbles_q <= perf_bubbles_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_bubbles = perf_bubbles_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain at default parameters.
module tb_pipe_reg_chain;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic [63:0]  in_payload;
    logic [2:0]   in_dst;
    logic         in_wr;
    logic         in_ready;
    logic [2:0]   stall;
    logic [2:0]   flush;
    logic [2:0]   res_we;
    logic [47:0]  res_data;
    logic [5:0]   q_idx;
    logic [1:0]   q_hit;
    logic [1:0]   q_pend;
    logic [31:0]  q_data;
    logic [2:0]   stg_valid;
    logic [191:0] stg_payload;
    logic         out_valid;
    logic         out_wr;
    logic [2:0]   out_dst;
    logic [15:0]  out_res;

    int n_checks = 0;
    int n_errors = 0;

    pipe_reg_chain dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_payload  (in_payload),
        .in_dst      (in_dst),
        .in_wr       (in_wr),
        .in_ready    (in_ready),
        .stall       (stall),
        .flush       (flush),
        .res_we      (res_we),
        .res_data    (res_data),
        .q_idx       (q_idx),
        .q_hit       (q_hit),
        .q_pend      (q_pend),
        .q_data      (q_data),
        .stg_valid   (stg_valid),
        .stg_payload (stg_payload),
        .out_valid   (out_valid),
        .out_wr      (out_wr),
        .out_dst     (out_dst),
        .out_res     (out_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] dst, input logic we0, input logic [15:0] rd0);
        in_valid        = 1'b1;
        in_wr           = 1'b1;
        in_dst          = dst;
        in_payload      = 64'hC0DE_0000_0000_0000 | 64'(dst);
        res_we          = {2'b00, we0};
        res_data[15:0]  = rd0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_wr    = 1'b0;
        res_we   = 3'b000;
        res_data = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_payload = '0;
        in_dst     = '0;
        in_wr      = 1'b0;
        stall      = '0;
        flush      = '0;
        res_we     = '0;
        res_data   = '0;
        q_idx      = '0;
        #2;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_stg_valid", 64'(stg_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_q_hit",     64'(q_hit),     64'd0);
        check("rst_q_pend",    64'(q_pend),    64'd0);
        check("rst_q_data",    64'(q_data),    64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back dst 1,2,3
        present(3'd1, 1'b0, 16'h0);
        tick();
        check("b2b_v1", 64'(stg_valid), 64'b001);
        present(3'd2, 1'b0, 16'h0);
        tick();
        check("b2b_out_early", 64'(out_valid), 64'd0);
        present(3'd3, 1'b0, 16'h0);
        tick();
        idle();
        check("b2b_out_v1",  64'(out_valid), 64'd1);
        check("b2b_out_d1",  64'(out_dst),   64'd1);
        check("b2b_out_wr",  64'(out_wr),    64'd1);
        check("b2b_pay2",    stg_payload[191:128], 64'hC0DE_0000_0000_0001);
        tick();
        check("b2b_out_d2",  64'(out_dst),   64'd2);
        tick();
        check("b2b_out_d3",  64'(out_dst),   64'd3);
        tick();
        check("b2b_drained", 64'(out_valid), 64'd0);

        // Result captured at stage 0 is forwarded
        present(3'd5, 1'b1, 16'h00AA);
        tick();
        idle();
        q_idx = {3'd6, 3'd5};
        #1;
        check("fwd_hit0",  64'(q_hit[0]),    64'd1);
        check("fwd_data0", 64'(q_data[15:0]), 64'h00AA);
        check("fwd_pend0", 64'(q_pend[0]),   64'd0);
        check("fwd_miss1", 64'({q_hit[1], q_pend[1], q_data[31:16]}), 64'd0);
        tick(); tick(); tick();

        // Younger pending writer shadows older ready one
        present(3'd4, 1'b1, 16'h1234);
        tick();
        present(3'd4, 1'b0, 16'h0);
        tick();
        idle();
        tick();
        q_idx = {3'd0, 3'd4};
        #1;
        check("yw_pend",    64'(q_pend[0]),  64'd1);
        check("yw_hit",     64'(q_hit[0]),   64'd0);
        check("yw_data",    64'(q_data[15:0]), 64'd0);
        check("yw_out_res", 64'(out_res),    64'h1234);
        tick();
        check("yw_out_dst", 64'(out_dst),    64'd4);
        check("yw_pend2",   64'(q_pend[0]),  64'd1);
        tick();
        check("yw_empty",   64'(stg_valid),  64'd0);

        // stall[1] for two cycles inserts bubbles into stage 2
        present(3'd1, 1'b0, 16'h0); tick();
        present(3'd2, 1'b0, 16'h0); tick();
        present(3'd3, 1'b0, 16'h0); tick();
        present(3'd6, 1'b0, 16'h0);
        stall = 3'b010;
        #1;
        check("st_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("st_valid1", 64'(stg_valid), 64'b011);
        tick();
        check("st_valid2", 64'(stg_valid), 64'b011);
        check("st_out",    64'(out_valid), 64'd0);
        check("st_pay1",   stg_payload[127:64], 64'hC0DE_0000_0000_0002);
        stall = 3'b000;
        #1;
        check("st_ready_rel", 64'(in_ready), 64'd1);
        tick();
        idle();
        check("st_res_d2", 64'(out_dst), 64'd2);
        tick();
        check("st_res_d3", 64'(out_dst), 64'd3);
        tick();
        check("st_res_d6", 64'(out_dst), 64'd6);
        tick();
        check("st_empty",  64'(stg_valid), 64'd0);

        // Flush stages 0,1 while stage 1 stalled
        present(3'd1, 1'b1, 16'h0011); tick();
        present(3'd2, 1'b1, 16'h0022); tick();
        present(3'd3, 1'b1, 16'h0033); tick();
        idle();
        q_idx = {3'd2, 3'd3};
        #1;
        check("fl_pre_hit", 64'(q_hit), 64'b11);
        stall = 3'b010;
        flush = 3'b011;
        tick();
        stall = 3'b000;
        flush = 3'b000;
        check("fl_valid", 64'(stg_valid), 64'b000);
        check("fl_hit",   64'(q_hit),     64'd0);
        check("fl_pend",  64'(q_pend),    64'd0);

        // Asynchronous reset mid-stream
        present(3'd1, 1'b1, 16'h0011); tick();
        present(3'd2, 1'b1, 16'h0022); tick();
        present(3'd3, 1'b1, 16'h0033); tick();
        idle();
        q_idx = {3'd1, 3'd3};
        #1;
        check("ar_pre_valid", 64'(stg_valid), 64'b111);
        check("ar_pre_hit",   64'(q_hit),     64'b11);
        reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(stg_valid), 64'd0);
        check("ar_out",   64'(out_valid), 64'd0);
        check("ar_hit",   64'(q_hit),     64'd0);
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised successor to the fixed three-stage decode/result shift registers. It carries an opaque decode payload through NUM_STAGES stages, each with a valid bit, a destination register index, a write flag and a result slot. It supports per-stage stall with bubble insertion, per-stage flush, and late result capture. It answers NUM_SRC combinational forwarding queries against in-flight results. Sits between decoder and execute/memory/writeback; the last stage drives register-file writeback.

Parameters:
NUM_STAGES, 3, number of stored stages (index 0 = youngest/execute, NUM_STAGES-1 = writeback); legal 2..8
PAYLOAD_W, 64, width of opaque decode payload
DATA_W, 16, result/register width
IDX_W, 3, register index width
NUM_SRC, 2, number of forwarding query ports

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decoder presents an instruction
in_payload  in  PAYLOAD_W  decode fields/enables
in_dst  in  IDX_W  destination register
in_wr  in  1  instruction writes in_dst
in_ready  out  1  stage 0 accepts this cycle
stall  in  NUM_STAGES  stall[k] freezes stage k and all younger stages
flush  in  NUM_STAGES  flush[k] invalidates stage k
res_we  in  NUM_STAGES  res_we[k]: capture res_data[k] into the entry entering stage k
res_data  in  NUM_STAGES*DATA_W  per-stage result (ALU, moves, memory)
q_idx  in  NUM_SRC*IDX_W  forwarding query register indices
q_hit  out  NUM_SRC  matching in-flight result is ready
q_pend  out  NUM_SRC  matching in-flight writer has no result yet (requester must stall)
q_data  out  NUM_SRC*DATA_W  forwarded value, 0 when no hit
stg_valid  out  NUM_STAGES  per-stage valid
stg_payload  out  NUM_STAGES*PAYLOAD_W  per-stage payload
out_valid, out_wr, out_dst, out_res  out  1,1,IDX_W,DATA_W  stage NUM_STAGES-1 contents for writeback

Behaviour:
- Reset (reset_n low, async): all valid, wr and res_ok bits = 0; payload, dst and res = 0. Consequently in_ready=1, all q_* = 0, out_valid=0. Mid-operation reset discards every in-flight entry immediately.
- hold[k] = OR(stall[k..NUM_STAGES-1]). in_ready = !hold[0]. Last stage retires every cycle unless held.
- Per-stage update each rising edge, priority order:
  - (1) flush[k]: valid<=0, other fields don't-care.
  - (2) hold[k]: keep all fields.
  - (3) k==0: load in_* (valid<=in_valid).
  - (3) k>0 with hold[k-1]=1: bubble, valid<=0.
  - (3) otherwise: shift from stage k-1.
- Result slot, on a load/shift into stage k:
  - res_we[k]=1: res<=res_data[k], res_ok<=1.
  - otherwise: carry res/res_ok from the source (input: res_ok=0).
  - Held stages ignore res_we.
- Flush beats stall in the same stage. A stalled younger stage that is also flushed becomes invalid but remains held.
- Forwarding, combinational, per query j:
  - Scan stages 0..NUM_STAGES-1; youngest match wins.
  - Match condition: valid & wr & dst==q_idx[j].
  - Match with res_ok: q_hit=1, q_data=res.
  - Match without res_ok: q_pend=1, q_hit=0, q_data=0.
  - No match: all 0.
  - An older ready match is never used when a younger pending match exists.
- out_* is pure wiring from the last stage, so latency from acceptance to out_valid is NUM_STAGES cycles absent stalls.
- The consumer writes the register file only when out_valid & out_wr.

Optional Feature:
Macro PIPE_REG_CHAIN_PERF_EN.
- Defined: adds outputs perf_retired, perf_bubbles, perf_flushed (32 bits each, saturating at all-ones, reset 0).
  - perf_retired counts cycles with out_valid & !hold[NUM_STAGES-1].
  - perf_bubbles counts cycles where any stage k>0 takes a bubble.
  - perf_flushed counts cycles with any flush bit set on a valid stage.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Defaults; present 3 instructions dst=1,2,3, wr=1 back-to-back with no stalls -> out_valid rises on cycle 3 after the first accept; out_dst sequence 1,2,3.
- res_we[0] with res_data[0]=16'h00AA on the dst=5 entry; next cycle q_idx[0]=5 -> q_hit=1, q_data=16'h00AA, q_pend=0.
- Entry dst=4 in stage 1 with no result and older stage 2 dst=4 res=16'h1234 ready; query 4 -> q_pend=1, q_hit=0 (youngest wins).
- stall=3'b010 for 2 cycles -> stages 0,1 frozen, in_ready=0, stage 2 receives 2 bubbles; after release the frozen entries resume in order with no loss or duplication.
- flush=3'b011 concurrent with stall[1]=1 -> stages 0,1 invalid next cycle; stage 2 shifts normally; no forwarding hits from the flushed entries.
- Assert reset_n low mid-stream with 3 valid entries -> stg_valid=0, out_valid=0 and q_hit=0 immediately, before any clock edge.
